// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: merges pipeline writebacks and a 2-entry multi-cycle queue onto one registered
// register-file write port. Define REGFILE_ARB_STARVE_EN to build the MC starvation guard.
module regfile_wr_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [63:0] wb_data,
  output logic        wb_ready,
  input  logic        mc_valid,
  input  logic [4:0]  mc_reg,
  input  logic [63:0] mc_data,
  output logic        mc_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData,
  output logic [31:0] pending,
  output logic [1:0]  mc_count
);
  logic [4:0]  reg_q [2];
  logic [4:0]  reg_d [2];
  logic [63:0] data_q [2];
  logic [63:0] data_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [4:0]  wa_q, wa_d;
  logic [63:0] wd_q, wd_d;
  logic        non_empty, starve, push, pop, issue, wr_idx;
  logic [4:0]  iss_reg;
  logic [63:0] iss_data;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

`ifdef REGFILE_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;
  assign starve = non_empty && (starve_q == 4'(STARVE_LIMIT));
  // Head wait counter: counts cycles the head is passed over, saturating; restarts for each new head
  always_comb begin
    starve_d = (!non_empty || pop) ? 4'd0 : (starve ? starve_q : starve_q + 4'd1);
  end
  // Starve counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= 4'd0;
    else starve_q <= starve_d;
  end
`else
  assign starve = 1'b0;
`endif

  // Source select: forced MC, else WB, else queue head; a new push never issues in its own cycle
  always_comb begin
    non_empty = cnt_q != 2'd0;
    mc_ready  = cnt_q != 2'd2;
    push      = mc_valid && mc_ready;
    pop       = starve || (!wb_valid && non_empty);
    issue     = pop || wb_valid;
    iss_reg   = pop ? reg_q[0] : wb_reg;
    iss_data  = pop ? data_q[0] : wb_data;
    wb_ready  = !starve;
    wr_idx    = cnt_q[1] || (cnt_q[0] && !pop);
  end

  // Queue shift/append and registered write port next state; writes to r31 are dropped
  always_comb begin
    reg_d  = reg_q;
    data_d = data_q;
    if (pop) begin
      reg_d[0]  = reg_q[1];
      data_d[0] = data_q[1];
    end
    if (push) begin
      reg_d[wr_idx]  = mc_reg;
      data_d[wr_idx] = mc_data;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rw_d  = issue && (iss_reg != 5'd31);
    wa_d  = rw_d ? iss_reg : wa_q;
    wd_d  = rw_d ? iss_data : wd_q;
  end

  // State registers; reset discards queued entries and any write not yet presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_q  <= '{default: '0};
      data_q <= '{default: '0};
      cnt_q  <= 2'd0;
      rw_q   <= 1'b0;
      wa_q   <= 5'd0;
      wd_q   <= 64'd0;
    end else begin
      reg_q  <= reg_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      rw_q   <= rw_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
    end
  end

  assign pending       = ((32'(cnt_q != 2'd0) << reg_q[0]) | (32'(cnt_q[1]) << reg_q[1])) & 32'h7FFF_FFFF;
  assign mc_count      = cnt_q;
  assign RegWrite      = rw_q;
  assign WriteRegister = wa_q;
  assign WriteData     = wd_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_regfile_wr_arbiter;
  localparam int LIM = 4;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, mc_valid;
  logic [4:0]  wb_reg, mc_reg;
  logic [63:0] wb_data, mc_data;
  logic        wb_ready, mc_ready, RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [31:0] pending;
  logic [1:0]  mc_count;

  regfile_wr_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .pending(pending), .mc_count(mc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  int n_cmp = 0;
  int n_fail = 0;
  ent_t mq[$];
  int mwait = 0;
  logic        exp_rw;
  logic [4:0]  exp_wa;
  logic [63:0] exp_wd;
  logic        e_wbr, e_mcr, o_wbr, o_mcr;
  logic [1:0]  e_cnt, o_cnt;
  logic [31:0] e_pend, o_pend;

  // One clock of stimulus; samples combinational outputs mid-cycle and advances the model.
  task automatic step(input logic wv, input logic [4:0] wr, input logic [63:0] wd,
                      input logic mv, input logic [4:0] mr, input logic [63:0] md);
    bit starve, popd, iss;
    logic [4:0] ir;
    logic [63:0] id;
    ent_t e;
    wb_valid = wv; wb_reg = wr; wb_data = wd;
    mc_valid = mv; mc_reg = mr; mc_data = md;
    #2;
    o_wbr = wb_ready; o_mcr = mc_ready; o_cnt = mc_count; o_pend = pending;
    starve = 0;
`ifdef REGFILE_ARB_STARVE_EN
    starve = (mq.size() > 0) && (mwait == LIM);
`endif
    e_wbr = !starve;
    e_mcr = mq.size() < 2;
    e_cnt = 2'(mq.size());
    e_pend = '0;
    foreach (mq[i]) if (mq[i].r != 5'd31) e_pend[mq[i].r] = 1'b1;
    popd = starve || (!wv && mq.size() > 0);
    iss = popd || wv;
    if (popd) begin ir = mq[0].r; id = mq[0].d; end
    else begin ir = wr; id = wd; end
    exp_rw = iss && ir != 5'd31;
    if (exp_rw) begin exp_wa = ir; exp_wd = id; end
    if (popd) void'(mq.pop_front());
    if (mv && e_mcr) begin e.r = mr; e.d = md; mq.push_back(e); end
    if (popd || e_cnt == 2'd0) mwait = 0;
    else if (mwait < LIM) mwait++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_valid = 0; wb_reg = 0; wb_data = 0; mc_valid = 0; mc_reg = 0; mc_data = 0;
    #12;
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset.RegWrite got %0h exp 0", RegWrite); end
    n_cmp++; if (WriteRegister !== 5'd0) begin n_fail++; $display("FAIL reset.WriteRegister got %0h exp 0", WriteRegister); end
    n_cmp++; if (WriteData !== 64'd0) begin n_fail++; $display("FAIL reset.WriteData got %0h exp 0", WriteData); end
    n_cmp++; if (mc_count !== 2'd0) begin n_fail++; $display("FAIL reset.mc_count got %0h exp 0", mc_count); end
    n_cmp++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset.pending got %0h exp 0", pending); end
    n_cmp++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset.mc_ready got %0h exp 1", mc_ready); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset.wb_ready got %0h exp 1", wb_ready); end
    #8 reset = 1'b1;
    mq.delete(); mwait = 0; exp_rw = 0; exp_wa = 0; exp_wd = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_wb_basic();
    step(1'b1, 5'd5, 64'hA0, 1'b0, 5'd0, 64'd0);
    n_cmp++; if (o_wbr !== 1'b1) begin n_fail++; $display("FAIL wb_basic.wb_ready got %0h exp 1", o_wbr); end
    n_cmp++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL wb_basic.RegWrite got %0h exp 1", RegWrite); end
    n_cmp++; if (WriteRegister !== 5'd5) begin n_fail++; $display("FAIL wb_basic.WriteRegister got %0h exp 5", WriteRegister); end
    n_cmp++; if (WriteData !== 64'hA0) begin n_fail++; $display("FAIL wb_basic.WriteData got %0h exp a0", WriteData); end
  endtask

  task automatic test_hold();
    idle();
    idle();
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL hold.RegWrite got %0h exp 0", RegWrite); end
    n_cmp++; if (WriteRegister !== 5'd5) begin n_fail++; $display("FAIL hold.WriteRegister got %0h exp 5", WriteRegister); end
    n_cmp++; if (WriteData !== 64'hA0) begin n_fail++; $display("FAIL hold.WriteData got %0h exp a0", WriteData); end
  endtask

  task automatic test_discard31();
    step(1'b1, 5'd31, 64'h1234, 1'b0, 5'd0, 64'd0);
    n_cmp++; if (o_wbr !== 1'b1) begin n_fail++; $display("FAIL discard31.wb_ready got %0h exp 1", o_wbr); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL discard31.RegWrite got %0h exp 0", RegWrite); end
  endtask

  task automatic test_mc_order();
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mc_order.first_RegWrite got %0h exp 0", RegWrite); end
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd8, 64'h88);
    n_cmp++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 64'h77)
      begin n_fail++; $display("FAIL mc_order.write7 got %0h/%0h/%0h exp 1/7/77", RegWrite, WriteRegister, WriteData); end
    idle();
    n_cmp++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd8 || WriteData !== 64'h88)
      begin n_fail++; $display("FAIL mc_order.write8 got %0h/%0h/%0h exp 1/8/88", RegWrite, WriteRegister, WriteData); end
    n_cmp++; if (mc_count !== 2'd0) begin n_fail++; $display("FAIL mc_order.mc_count got %0h exp 0", mc_count); end
  endtask

  task automatic test_starve();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 5'd10, 64'(k), k < 3, 5'(k + 1), 64'h100 + 64'(k));
      n_cmp++; if (o_wbr !== e_wbr) begin n_fail++; $display("FAIL starve.wb_ready[%0d] got %0h exp %0h", k, o_wbr, e_wbr); end
      n_cmp++; if (o_pend !== e_pend) begin n_fail++; $display("FAIL starve.pending[%0d] got %0h exp %0h", k, o_pend, e_pend); end
      n_cmp++; if (RegWrite !== exp_rw || WriteRegister !== exp_wa)
        begin n_fail++; $display("FAIL starve.write[%0d] got %0h/%0h exp %0h/%0h", k, RegWrite, WriteRegister, exp_rw, exp_wa); end
`ifdef REGFILE_ARB_STARVE_EN
      if (k == 5) begin
        n_cmp++; if (o_wbr !== 1'b0) begin n_fail++; $display("FAIL starve.forced_wb_ready got %0h exp 0", o_wbr); end
        n_cmp++; if (WriteRegister !== 5'd1 || RegWrite !== 1'b1)
          begin n_fail++; $display("FAIL starve.forced_write got %0h/%0h exp 1/1", RegWrite, WriteRegister); end
      end
      if (k == 6) begin
        n_cmp++; if (o_pend !== 32'h4) begin n_fail++; $display("FAIL starve.pending_drop got %0h exp 4", o_pend); end
      end
`else
      if (k >= 3) begin
        n_cmp++; if (o_pend !== 32'h6 || o_cnt !== 2'd2 || o_mcr !== 1'b0)
          begin n_fail++; $display("FAIL starve.blocked[%0d] got pend=%0h cnt=%0h rdy=%0h exp 6/2/0", k, o_pend, o_cnt, o_mcr); end
        n_cmp++; if (WriteRegister !== 5'd10) begin n_fail++; $display("FAIL starve.no_mc[%0d] got %0h exp a", k, WriteRegister); end
      end
`endif
    end
    for (int k = 0; k < 3; k++) idle();
    n_cmp++; if (mc_count !== 2'd0) begin n_fail++; $display("FAIL starve.drain got %0h exp 0", mc_count); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 5'd10, 64'h10, 1'b1, 5'd4, 64'h44);
    step(1'b1, 5'd11, 64'h11, 1'b1, 5'd5, 64'h55);
    n_cmp++; if (mc_count !== 2'd2) begin n_fail++; $display("FAIL reset_mid.full got %0h exp 2", mc_count); end
    reset = 1'b0;
    #1;
    n_cmp++; if (mc_count !== 2'd0) begin n_fail++; $display("FAIL reset_mid.mc_count got %0h exp 0", mc_count); end
    n_cmp++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_mid.pending got %0h exp 0", pending); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_mid.RegWrite got %0h exp 0", RegWrite); end
    wb_valid = 0; mc_valid = 0;
    #3 reset = 1'b1;
    mq.delete(); mwait = 0; exp_rw = 0; exp_wa = 0; exp_wd = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      idle();
      n_cmp++; if (RegWrite !== 1'b0 || mc_count !== 2'd0)
        begin n_fail++; $display("FAIL reset_mid.after[%0d] got %0h/%0h exp 0/0", k, RegWrite, mc_count); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      n_cmp++; if (o_wbr !== e_wbr || o_mcr !== e_mcr || o_cnt !== e_cnt || o_pend !== e_pend)
        begin n_fail++; $display("FAIL random.comb[%0d] got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h",
                                 k, o_wbr, o_mcr, o_cnt, o_pend, e_wbr, e_mcr, e_cnt, e_pend); end
      n_cmp++; if (RegWrite !== exp_rw) begin n_fail++; $display("FAIL random.RegWrite[%0d] got %0h exp %0h", k, RegWrite, exp_rw); end
      if (exp_rw) begin
        n_cmp++; if (WriteRegister !== exp_wa || WriteData !== exp_wd)
          begin n_fail++; $display("FAIL random.write[%0d] got %0h/%0h exp %0h/%0h", k, WriteRegister, WriteData, exp_wa, exp_wd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_basic();
    test_hold();
    test_discard31();
    test_mc_order();
    test_starve();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
